cuppa_wvb_hdr_unpack_fifo: RTL and testbench
============================================

// Module: cuppa_wvb_hdr_unpack_fifo
// PURPOSE
//  Parametrised successor to the combinational waveform-buffer header fan-out.
//  Buffers packed header bundles from the waveform-buffer writer in a sync FIFO
//  and presents the head entry as unpacked fields, under a valid/ready handshake.
//  Adds a derived waveform length, a delivered-header count and an LTC-order check.
//  Sits between the wvb header writer and the readout/packetiser FSM.
// PARAMETERS
//  P_LTC_W   48  event LTC timestamp width
//  P_ADR_W   15  waveform buffer address width (start/stop)
//  P_TRIG_W   2  trigger source width
//  P_CONF_W   6  pre-trigger config width
//  P_DEPTH    4  FIFO entries; power of 2, >= 2
//  P_CNT_W   32  delivered-header counter width
//  derived: L_BUN_W = P_LTC_W+2*P_ADR_W+P_TRIG_W+1+P_CONF_W (87 at defaults)
// PORTS
//  clk         in   1              system clock
//  rst         in   1              synchronous, active-high reset
//  in_bundle   in   L_BUN_W        packed header, LSB first: evt_ltc,start_addr,stop_addr,trig_src,cnst_run,pre_conf
//  in_vld      in   1              in_bundle valid
//  in_rdy      out  1              FIFO can accept
//  out_vld     out  1              head entry valid
//  out_rdy     in   1              consumer accepts head
//  evt_ltc     out  P_LTC_W        head field
//  start_addr  out  P_ADR_W        head field
//  stop_addr   out  P_ADR_W        head field
//  trig_src    out  P_TRIG_W       head field
//  cnst_run    out  1              head field
//  pre_conf    out  P_CONF_W       head field
//  wvb_len     out  P_ADR_W+1      samples in waveform: ((stop-start) mod 2^P_ADR_W)+1
//  fill        out  clog2(DEPTH)+1 current occupancy
//  hdr_cnt     out  P_CNT_W        headers popped since reset, saturating
//  err_ltc     out  1              sticky: popped LTC <= previous popped LTC
// BEHAVIOUR
//  - Push when in_vld&&in_rdy; pop when out_vld&&out_rdy. in_rdy = !full (no bypass).
//  - Full and pop same cycle: in_rdy still low, no push; fill drops by 1.
//  - Push+pop same cycle (not full, not empty): fill unchanged.
//  - Latency: bundle pushed in cycle N into empty FIFO -> out_vld and fields valid cycle N+1.
//  - Output fields/wvb_len are registered, update the cycle after pop or first push; hold while !out_rdy.
//  - wvb_len: unsigned subtract modulo 2^P_ADR_W then +1 at P_ADR_W+1 bits; stop==start -> 1; stop<start wraps.
//  - hdr_cnt +1 per pop, saturates at all-ones.
//  - err_ltc: compare on each pop vs last popped LTC; first pop after reset never flags; once set stays until rst.
//  - Reset: FIFO flushed, in_rdy=0, out_vld=0, all field outputs/wvb_len/fill/hdr_cnt/err_ltc=0;
//    in_rdy=1 the first cycle rst is low. Reset mid-operation discards all entries, no partial pop.
//  - Pointers wrap modulo P_DEPTH; fill distinguishes full (P_DEPTH) from empty (0).
// STRUCTURE
//  - Package cuppa_wvb_hdr_pkg: width params, field LSB offsets, L_BUN_W function, unpack function.
//  - Sub-module cuppa_wvb_hdr_fifo: generic sync FIFO (width, depth), FWFT registered head.
//  - Top: FIFO instance + unpack, wvb_len arithmetic, counter, LTC-order checker.
// TESTING
//  - Reset: hold rst 3 cycles -> all outputs 0; cycle after release in_rdy=1, out_vld=0.
//  - Single header ltc=0x10,start=100,stop=163 -> out_vld next cycle, wvb_len=64, hdr_cnt=1 after pop.
//  - Wrap: start=0x7FF0,stop=0x000F -> wvb_len=32; start=stop=5 -> wvb_len=1.
//  - Fill: push 4 with out_rdy=0 -> fill=4,in_rdy=0; pop one with in_vld=1 -> no push, fill=3.
//  - Order: pop ltc 200 then 150 -> err_ltc=1 and stays; equal LTC also flags; rst clears.
//  - Mid-op reset with fill=3 -> fill=0,out_vld=0 next cycle; no stale entry after release.

Source files
------------

// File: rtl/cuppa_wvb_hdr_pkg.sv
// Shared widths, bundle field offsets and unpack helpers for the wvb header FIFO.
package cuppa_wvb_hdr_pkg;

    localparam int unsigned L_LTC_W  = 48;
    localparam int unsigned L_ADR_W  = 15;
    localparam int unsigned L_TRIG_W = 2;
    localparam int unsigned L_CONF_W = 6;
    localparam int unsigned L_DEPTH  = 4;
    localparam int unsigned L_CNT_W  = 32;

    function automatic int unsigned bun_w(input int unsigned ltc_w, input int unsigned adr_w,
                                          input int unsigned trig_w, input int unsigned conf_w);
        return ltc_w + 2 * adr_w + trig_w + 1 + conf_w;
    endfunction

    // Field LSB offsets inside the packed bundle (evt_ltc sits at bit 0).
    function automatic int unsigned off_start(input int unsigned ltc_w);
        return ltc_w;
    endfunction

    function automatic int unsigned off_stop(input int unsigned ltc_w, input int unsigned adr_w);
        return ltc_w + adr_w;
    endfunction

    function automatic int unsigned off_trig(input int unsigned ltc_w, input int unsigned adr_w);
        return ltc_w + 2 * adr_w;
    endfunction

    function automatic int unsigned off_cnst(input int unsigned ltc_w, input int unsigned adr_w,
                                             input int unsigned trig_w);
        return ltc_w + 2 * adr_w + trig_w;
    endfunction

    function automatic int unsigned off_conf(input int unsigned ltc_w, input int unsigned adr_w,
                                             input int unsigned trig_w);
        return ltc_w + 2 * adr_w + trig_w + 1;
    endfunction

    localparam int unsigned L_BUN_W = bun_w(L_LTC_W, L_ADR_W, L_TRIG_W, L_CONF_W);

    typedef struct packed {
        logic [L_CONF_W-1:0] pre_conf;
        logic                cnst_run;
        logic [L_TRIG_W-1:0] trig_src;
        logic [L_ADR_W-1:0]  stop_addr;
        logic [L_ADR_W-1:0]  start_addr;
        logic [L_LTC_W-1:0]  evt_ltc;
    } hdr_t;

    function automatic hdr_t unpack_hdr(input logic [L_BUN_W-1:0] bundle);
        return hdr_t'(bundle);
    endfunction

endpackage

// File: rtl/cuppa_wvb_hdr_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
module cuppa_wvb_hdr_fifo #(
    parameter int unsigned P_W     = 8,
    parameter int unsigned P_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [P_W-1:0]           in_data,
    input  logic                     in_vld,
    output logic                     in_rdy,
    output logic [P_W-1:0]           out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [$clog2(P_DEPTH):0] fill
);

    localparam int unsigned L_AW = $clog2(P_DEPTH);
    localparam int unsigned L_CW = L_AW + 1;

    logic [P_W-1:0]  mem [P_DEPTH];
    logic [L_AW-1:0] wr_ptr;
    logic [L_AW-1:0] rd_ptr;
    logic [L_AW-1:0] rd_nxt;
    logic [L_CW-1:0] cnt;
    logic [L_CW-1:0] cnt_nxt;
    logic            push;
    logic            pop;
    logic            full;

    assign full   = (cnt == L_CW'(P_DEPTH));
    assign in_rdy = !rst && !full;
    assign push   = in_vld && in_rdy;
    assign pop    = out_vld && out_rdy;
    assign fill   = cnt;

    always_comb begin
        rd_nxt  = rd_ptr + L_AW'(pop);
        cnt_nxt = cnt + L_CW'(push) - L_CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // The head register reloads only when the current head leaves or the FIFO was empty;
    // a push landing exactly at the new read slot bypasses the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + L_AW'(1);
            end
            rd_ptr  <= rd_nxt;
            cnt     <= cnt_nxt;
            out_vld <= (cnt_nxt != '0);
            if ((pop || cnt == '0) && cnt_nxt != '0) begin
                out_data <= (push && wr_ptr == rd_nxt) ? in_data : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/cuppa_wvb_hdr_unpack_fifo.sv
// Buffers packed wvb headers and presents the head as unpacked fields plus
// derived waveform length, delivered-header count and LTC-order error flag.
module cuppa_wvb_hdr_unpack_fifo
    import cuppa_wvb_hdr_pkg::*;
#(
    parameter int unsigned P_LTC_W  = L_LTC_W,
    parameter int unsigned P_ADR_W  = L_ADR_W,
    parameter int unsigned P_TRIG_W = L_TRIG_W,
    parameter int unsigned P_CONF_W = L_CONF_W,
    parameter int unsigned P_DEPTH  = L_DEPTH,
    parameter int unsigned P_CNT_W  = L_CNT_W
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [bun_w(P_LTC_W, P_ADR_W, P_TRIG_W, P_CONF_W)-1:0] in_bundle,
    input  logic                                                  in_vld,
    output logic                                                  in_rdy,
    output logic                                                  out_vld,
    input  logic                                                  out_rdy,
    output logic [P_LTC_W-1:0]                                    evt_ltc,
    output logic [P_ADR_W-1:0]                                    start_addr,
    output logic [P_ADR_W-1:0]                                    stop_addr,
    output logic [P_TRIG_W-1:0]                                   trig_src,
    output logic                                                  cnst_run,
    output logic [P_CONF_W-1:0]                                   pre_conf,
    output logic [P_ADR_W:0]                                      wvb_len,
    output logic [$clog2(P_DEPTH):0]                              fill,
    output logic [P_CNT_W-1:0]                                    hdr_cnt,
    output logic                                                  err_ltc
);

    localparam int unsigned L_BW      = bun_w(P_LTC_W, P_ADR_W, P_TRIG_W, P_CONF_W);
    localparam int unsigned L_LEN_W   = P_ADR_W + 1;
    localparam int unsigned L_PW      = L_BW + L_LEN_W;
    localparam int unsigned L_O_START = off_start(P_LTC_W);
    localparam int unsigned L_O_STOP  = off_stop(P_LTC_W, P_ADR_W);
    localparam int unsigned L_O_TRIG  = off_trig(P_LTC_W, P_ADR_W);
    localparam int unsigned L_O_CNST  = off_cnst(P_LTC_W, P_ADR_W, P_TRIG_W);
    localparam int unsigned L_O_CONF  = off_conf(P_LTC_W, P_ADR_W, P_TRIG_W);

    logic [P_ADR_W-1:0] len_diff;
    logic [L_LEN_W-1:0] len_in;
    logic [L_PW-1:0]    push_data;
    logic [L_PW-1:0]    head;
    logic               pop;
    logic               ltc_seen;
    logic [P_LTC_W-1:0] last_ltc;

    // Length is computed on entry so it travels with the header as a registered head field.
    always_comb begin
        len_diff  = in_bundle[L_O_STOP +: P_ADR_W] - in_bundle[L_O_START +: P_ADR_W];
        len_in    = L_LEN_W'(len_diff) + L_LEN_W'(1);
        push_data = {len_in, in_bundle};
    end

    cuppa_wvb_hdr_fifo #(
        .P_W     (L_PW),
        .P_DEPTH (P_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_data  (push_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (head),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .fill     (fill)
    );

    assign evt_ltc    = head[0 +: P_LTC_W];
    assign start_addr = head[L_O_START +: P_ADR_W];
    assign stop_addr  = head[L_O_STOP +: P_ADR_W];
    assign trig_src   = head[L_O_TRIG +: P_TRIG_W];
    assign cnst_run   = head[L_O_CNST];
    assign pre_conf   = head[L_O_CONF +: P_CONF_W];
    assign wvb_len    = head[L_BW +: L_LEN_W];
    assign pop        = out_vld && out_rdy;

    // Delivered-header counter and sticky non-increasing LTC detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt  <= '0;
            err_ltc  <= 1'b0;
            ltc_seen <= 1'b0;
            last_ltc <= '0;
        end else if (pop) begin
            if (hdr_cnt != '1) begin
                hdr_cnt <= hdr_cnt + P_CNT_W'(1);
            end
            if (ltc_seen && evt_ltc <= last_ltc) begin
                err_ltc <= 1'b1;
            end
            ltc_seen <= 1'b1;
            last_ltc <= evt_ltc;
        end
    end

endmodule

// File: tb/tb_cuppa_wvb_hdr_unpack_fifo.sv
// Self-checking bench for cuppa_wvb_hdr_unpack_fifo: directed table, corner sequences, random run.
module tb_cuppa_wvb_hdr_unpack_fifo;

    localparam int DEPTH = 4;

    typedef struct {
        logic [47:0] ltc;
        logic [14:0] start;
        logic [14:0] stop;
        logic [1:0]  trig;
        logic        cnst;
        logic [5:0]  conf;
    } hdr_rec_t;

    typedef struct {
        hdr_rec_t    h;
        logic [15:0] exp_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [86:0] in_bundle;
    logic        in_vld;
    logic        in_rdy;
    logic        out_vld;
    logic        out_rdy;
    logic [47:0] evt_ltc;
    logic [14:0] start_addr;
    logic [14:0] stop_addr;
    logic [1:0]  trig_src;
    logic        cnst_run;
    logic [5:0]  pre_conf;
    logic [15:0] wvb_len;
    logic [2:0]  fill;
    logic [31:0] hdr_cnt;
    logic        err_ltc;

    cuppa_wvb_hdr_unpack_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_bundle  (in_bundle),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .evt_ltc    (evt_ltc),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .trig_src   (trig_src),
        .cnst_run   (cnst_run),
        .pre_conf   (pre_conf),
        .wvb_len    (wvb_len),
        .fill       (fill),
        .hdr_cnt    (hdr_cnt),
        .err_ltc    (err_ltc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    hdr_rec_t    m_q[$];
    logic [31:0] m_cnt;
    logic        m_err;
    logic        m_seen;
    logic [47:0] m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_len(input hdr_rec_t h);
        return ((int'(h.stop) - int'(h.start) + 32768) % 32768) + 1;
    endfunction

    task automatic drive(input hdr_rec_t h);
        in_bundle = {h.conf, h.cnst, h.trig, h.stop, h.start, h.ltc};
    endtask

    function automatic hdr_rec_t rand_hdr();
        hdr_rec_t h;
        h.ltc   = {16'($urandom), 32'($urandom)};
        h.start = 15'($urandom);
        h.stop  = 15'($urandom);
        h.trig  = 2'($urandom);
        h.cnst  = 1'($urandom);
        h.conf  = 6'($urandom);
        return h;
    endfunction

    function automatic hdr_rec_t mk_hdr(input logic [47:0] ltc, input logic [14:0] start,
                                        input logic [14:0] stop);
        hdr_rec_t h;
        h.ltc = ltc; h.start = start; h.stop = stop;
        h.trig = 2'd2; h.cnst = 1'b1; h.conf = 6'h2A;
        return h;
    endfunction

    task automatic check_all();
        hdr_rec_t h;
        chk("fill", 64'(fill), 64'(m_q.size()));
        chk("in_rdy", 64'(in_rdy), 64'(!rst && m_q.size() < DEPTH));
        chk("out_vld", 64'(out_vld), 64'(m_q.size() > 0));
        chk("hdr_cnt", 64'(hdr_cnt), 64'(m_cnt));
        chk("err_ltc", 64'(err_ltc), 64'(m_err));
        if (m_q.size() > 0) begin
            h = m_q[0];
            chk("evt_ltc", 64'(evt_ltc), 64'(h.ltc));
            chk("start_addr", 64'(start_addr), 64'(h.start));
            chk("stop_addr", 64'(stop_addr), 64'(h.stop));
            chk("trig_src", 64'(trig_src), 64'(h.trig));
            chk("cnst_run", 64'(cnst_run), 64'(h.cnst));
            chk("pre_conf", 64'(pre_conf), 64'(h.conf));
            chk("wvb_len", 64'(wvb_len), 64'(model_len(h)));
        end
    endtask

    // One clock: decide transfers from the model, advance it at the edge, then compare.
    task automatic cycle();
        bit       push;
        bit       pop;
        hdr_rec_t nh;
        hdr_rec_t h;
        push = !rst && in_vld && m_q.size() < DEPTH;
        pop  = !rst && m_q.size() > 0 && out_rdy;
        nh.ltc   = in_bundle[47:0];
        nh.start = in_bundle[62:48];
        nh.stop  = in_bundle[77:63];
        nh.trig  = in_bundle[79:78];
        nh.cnst  = in_bundle[80];
        nh.conf  = in_bundle[86:81];
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_cnt = '0; m_err = 1'b0; m_seen = 1'b0; m_last = '0;
        end else begin
            if (pop) begin
                h = m_q.pop_front();
                if (m_seen && h.ltc <= m_last) m_err = 1'b1;
                m_seen = 1'b1;
                m_last = h.ltc;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
            if (push) m_q.push_back(nh);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_one(input hdr_rec_t h);
        drive(h);
        in_vld = 1'b1; out_rdy = 1'b0;
        cycle();
        in_vld = 1'b0;
    endtask

    task automatic pop_one();
        out_rdy = 1'b1;
        cycle();
        out_rdy = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_bundle = '0;
        m_cnt = '0; m_err = 1'b0; m_seen = 1'b0; m_last = '0;

        vecs[0] = '{h: mk_hdr(48'h10, 15'd100, 15'd163), exp_len: 16'd64};
        vecs[1] = '{h: mk_hdr(48'h20, 15'h7FF0, 15'h000F), exp_len: 16'd32};
        vecs[2] = '{h: mk_hdr(48'h30, 15'd5, 15'd5), exp_len: 16'd1};
        vecs[3] = '{h: mk_hdr(48'h40, 15'h0000, 15'h7FFF), exp_len: 16'h8000};
        vecs[4] = '{h: mk_hdr(48'h50, 15'h7FFF, 15'h0000), exp_len: 16'd2};

        // Reset: all outputs zero while held, in_rdy high on the first cycle after release.
        do_reset(3);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_fields", 64'({evt_ltc, start_addr}), 64'd0);
        chk("rst_misc", 64'({stop_addr, trig_src, cnst_run, pre_conf}), 64'd0);
        chk("rst_len", 64'(wvb_len), 64'd0);
        chk("rst_cnt", 64'({hdr_cnt, fill, err_ltc}), 64'd0);

        // Table: one header at a time, length compared against hand-derived values.
        for (int i = 0; i < 5; i++) begin
            push_one(vecs[i].h);
            chk("tbl_vld", 64'(out_vld), 64'd1);
            chk("tbl_len", 64'(wvb_len), 64'(vecs[i].exp_len));
            chk("tbl_ltc", 64'(evt_ltc), 64'(vecs[i].h.ltc));
            pop_one();
            chk("tbl_cnt", 64'(hdr_cnt), 64'(i + 1));
        end

        // Fill to full, then pop with in_vld held: no push, occupancy drops to 3.
        for (int i = 0; i < DEPTH; i++) push_one(mk_hdr(48'h100 + 48'(i), 15'(i), 15'(i + 7)));
        chk("full_fill", 64'(fill), 64'd4);
        chk("full_rdy", 64'(in_rdy), 64'd0);
        drive(mk_hdr(48'h200, 15'd1, 15'd2));
        in_vld = 1'b1; out_rdy = 1'b1;
        cycle();
        in_vld = 1'b0; out_rdy = 1'b0;
        chk("full_pop_fill", 64'(fill), 64'd3);
        chk("full_pop_head", 64'(evt_ltc), 64'h101);
        // Simultaneous push and pop below full keeps occupancy.
        drive(mk_hdr(48'h300, 15'd9, 15'd9));
        in_vld = 1'b1; out_rdy = 1'b1;
        cycle();
        in_vld = 1'b0; out_rdy = 1'b0;
        chk("pp_fill", 64'(fill), 64'd3);
        for (int i = 0; i < 3; i++) pop_one();

        // LTC ordering: decreasing flags and sticks; reset clears; equal also flags.
        do_reset(1);
        push_one(mk_hdr(48'd200, 15'd0, 15'd1));
        push_one(mk_hdr(48'd150, 15'd0, 15'd1));
        push_one(mk_hdr(48'd900, 15'd0, 15'd1));
        pop_one();
        chk("ord_first", 64'(err_ltc), 64'd0);
        pop_one();
        chk("ord_dec", 64'(err_ltc), 64'd1);
        pop_one();
        chk("ord_sticky", 64'(err_ltc), 64'd1);
        do_reset(1);
        chk("ord_rst", 64'(err_ltc), 64'd0);
        push_one(mk_hdr(48'd300, 15'd0, 15'd1));
        push_one(mk_hdr(48'd300, 15'd0, 15'd1));
        pop_one();
        pop_one();
        chk("ord_eq", 64'(err_ltc), 64'd1);

        // Mid-operation reset with three entries queued.
        do_reset(1);
        for (int i = 0; i < 3; i++) push_one(mk_hdr(48'h400 + 48'(i), 15'd3, 15'd4));
        out_rdy = 1'b1;
        rst = 1'b1;
        cycle();
        chk("mid_fill", 64'(fill), 64'd0);
        chk("mid_vld", 64'(out_vld), 64'd0);
        rst = 1'b0;
        cycle();
        cycle();
        chk("mid_stale", 64'(out_vld), 64'd0);
        out_rdy = 1'b0;

        // Random traffic against the queue model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(rand_hdr());
            in_vld  = ($urandom_range(0, 99) < 60);
            out_rdy = ($urandom_range(0, 99) < 50);
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
